compute_stage: RTL and testbench

- Parametrised, registered successor to the CPU's combinational ALU result mux.
- Selects one of NUM_SRC candidate results and derives N/Z/C/V.
- Updates a persistent status-flag register under a per-operation mask.
- Buffers results in a DEPTH-entry in-order FIFO with valid/ready handshakes, so the control FSM and the register-file write-back can stall independently.

---
 rtl/compute_stage.sv | 132 +++++++++++++
 tb/tb_compute_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_stage.sv
// compute_stage: registered ALU result select with N/Z/C/V derivation,
// a masked persistent status register and an in-order result FIFO with
// valid/ready handshakes on both sides.
module compute_stage #(
  parameter int WIDTH       = 8,
  parameter int NUM_SRC     = 27,
  parameter int SEL_W       = 5,
  parameter int DEFAULT_SRC = 26,
  parameter int DEPTH       = 2,
  parameter int DEST_W      = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_carry,
  input  logic [NUM_SRC-1:0]       src_ovf,
  input  logic [SEL_W-1:0]         select,
  input  logic [DEST_W-1:0]        dest,
  input  logic [3:0]               flag_mask,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         Dout,
  output logic [DEST_W-1:0]        out_dest,
  output logic [3:0]               out_flags,
  output logic [3:0]               status
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [SEL_W:0]   NUM_SRC_EXT = (SEL_W + 1)'(NUM_SRC);
  localparam logic [SEL_W-1:0] DEFAULT_SEL = SEL_W'(DEFAULT_SRC);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(DEPTH - 1);

  // Flag vector ordered {N,V,Z,C} to line up with flag_mask and status.
  function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] res,
                                            input logic carry,
                                            input logic ovf);
    calc_flags = {res[WIDTH-1], ovf, (res == '0), carry};
  endfunction

  // Pointer increment with explicit wrap so non-power-of-two pointer
  // ranges (including DEPTH=1) never step outside the storage.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [SEL_W-1:0]  w_sel_eff;
  logic [WIDTH-1:0]  w_result;
  logic              w_carry;
  logic              w_ovf;
  logic [3:0]        w_new_flags;
  logic [3:0]        w_status_next;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  logic [3:0]        r_status;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [WIDTH-1:0]  r_mem_data  [DEPTH];
  logic [DEST_W-1:0] r_mem_dest  [DEPTH];
  logic [3:0]        r_mem_flags [DEPTH];

  // Out-of-range selects fall back to the stack-pointer pass-through source.
  assign w_sel_eff     = ({1'b0, select} < NUM_SRC_EXT) ? select : DEFAULT_SEL;
  assign w_result      = src_data[w_sel_eff*WIDTH +: WIDTH];
  assign w_carry       = src_carry[w_sel_eff];
  assign w_ovf         = src_ovf[w_sel_eff];
  assign w_new_flags   = calc_flags(w_result, w_carry, w_ovf);
  assign w_status_next = (flag_mask & w_new_flags) | (~flag_mask & r_status);

  // Handshake: ready depends on occupancy only, never on out_ready.
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid & ~w_full;
  assign w_pop   = ~w_empty & out_ready;

  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;
  assign status    = r_status;
  assign Dout      = r_mem_data[r_rd_ptr];
  assign out_dest  = r_mem_dest[r_rd_ptr];
  assign out_flags = r_mem_flags[r_rd_ptr];

  // Status register: masked merge of the new flags on every accepted op.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_status <= '0;
    end else if (w_push) begin
      r_status <= w_status_next;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i]  <= '0;
        r_mem_dest[i]  <= '0;
        r_mem_flags[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_ptr]  <= w_result;
      r_mem_dest[r_wr_ptr]  <= dest;
      r_mem_flags[r_wr_ptr] <= w_status_next;
    end
  end

endmodule

// File: tb/tb_compute_stage.sv
// Scoreboard bench for compute_stage: directed operations push hand-computed
// expected entries; a monitor pops and compares whenever the head is taken.
module tb_compute_stage;

  logic         Clk;
  logic         Reset;
  logic [215:0] src_data;
  logic [26:0]  src_carry;
  logic [26:0]  src_ovf;
  logic [4:0]   select;
  logic [2:0]   dest;
  logic [3:0]   flag_mask;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   Dout;
  logic [2:0]   out_dest;
  logic [3:0]   out_flags;
  logic [3:0]   status;

  // Second instance for the wide-datapath parameter set.
  logic [63:0]  src_data2;
  logic [3:0]   src_carry2;
  logic [3:0]   src_ovf2;
  logic [1:0]   select2;
  logic [2:0]   dest2;
  logic [3:0]   flag_mask2;
  logic         in_valid2;
  logic         in_ready2;
  logic         out_valid2;
  logic         out_ready2;
  logic [15:0]  Dout2;
  logic [2:0]   out_dest2;
  logic [3:0]   out_flags2;
  logic [3:0]   status2;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] dst;
    logic [3:0] f;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   errors = 0;
  int   checks = 0;

  compute_stage dut (
    .Clk(Clk), .Reset(Reset), .src_data(src_data), .src_carry(src_carry),
    .src_ovf(src_ovf), .select(select), .dest(dest), .flag_mask(flag_mask),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .Dout(Dout), .out_dest(out_dest),
    .out_flags(out_flags), .status(status)
  );

  compute_stage #(
    .WIDTH(16), .NUM_SRC(4), .SEL_W(2), .DEFAULT_SRC(3), .DEPTH(4), .DEST_W(3)
  ) dut2 (
    .Clk(Clk), .Reset(Reset), .src_data(src_data2), .src_carry(src_carry2),
    .src_ovf(src_ovf2), .select(select2), .dest(dest2), .flag_mask(flag_mask2),
    .in_valid(in_valid2), .in_ready(in_ready2), .out_valid(out_valid2),
    .out_ready(out_ready2), .Dout(Dout2), .out_dest(out_dest2),
    .out_flags(out_flags2), .status(status2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_src(input int idx, input logic [7:0] d, input logic c, input logic v);
    src_data[idx*8 +: 8] = d;
    src_carry[idx]       = c;
    src_ovf[idx]         = v;
  endtask

  // Present one operation and hold it until accepted; the expected FIFO
  // entry is queued at the edge where the DUT accepts it.
  task automatic issue(input logic [4:0] sel, input logic [2:0] d, input logic [3:0] m,
                       input logic [7:0] exp_d, input logic [3:0] exp_f);
    bit done;
    done      = 1'b0;
    select    = sel;
    dest      = d;
    flag_mask = m;
    in_valid  = 1'b1;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge Clk);
      if (in_ready) begin
        q.push_back('{d: exp_d, dst: d, f: exp_f});
        done = 1'b1;
      end
      @(posedge Clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept, expected accept of %0h", exp_d);
    end else begin
      chk("status_after_op", status, exp_f);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && (q.size() != 0 || out_valid); t++) begin
      @(posedge Clk);
      #2;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Monitor: compares the head against the scoreboard whenever it is popped.
  always @(negedge Clk) begin
    if (!Reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got Dout=%0h, expected no output", Dout);
      end else begin
        e_mon = q.pop_front();
        chk("Dout", Dout, e_mon.d);
        chk("out_dest", out_dest, e_mon.dst);
        chk("out_flags", out_flags, e_mon.f);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; src_data = '0; src_carry = '0; src_ovf = '0;
    select = '0; dest = '0; flag_mask = '0; in_valid = 1'b0; out_ready = 1'b0;
    src_data2 = '0; src_carry2 = '0; src_ovf2 = '0; select2 = '0; dest2 = '0;
    flag_mask2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    // Reset state
    @(negedge Clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_status", status, 0);
    chk("rst_Dout", Dout, 0);
    chk("rst_out_dest", out_dest, 0);
    chk("rst_out_flags", out_flags, 0);
    @(posedge Clk); #1;

    // Basic select, all flags updated; one-cycle latency
    set_src(0, 8'h80, 1'b1, 1'b0);
    issue(5'd0, 3'd1, 4'hF, 8'h80, 4'b1001);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_Dout", Dout, 8'h80);
    chk("lat_out_flags", out_flags, 4'b1001);
    out_ready = 1'b1;
    drain();

    // Out-of-range select falls back to source 26, Z-only mask
    set_src(26, 8'h00, 1'b0, 1'b0);
    issue(5'd30, 3'd2, 4'b0010, 8'h00, 4'b1011);
    drain();

    // Back-pressure: third op held while FIFO full
    out_ready = 1'b0;
    set_src(3, 8'h11, 1'b0, 1'b0);
    set_src(4, 8'h22, 1'b1, 1'b0);
    set_src(5, 8'h33, 1'b0, 1'b1);
    issue(5'd3, 3'd3, 4'hF, 8'h11, 4'b0000);
    issue(5'd4, 3'd4, 4'hF, 8'h22, 4'b0001);
    chk("full_in_ready", in_ready, 0);
    fork
      issue(5'd5, 3'd5, 4'b0100, 8'h33, 4'b0101);
      begin
        repeat (3) @(negedge Clk);
        chk("held_status", status, 4'b0001);
        chk("held_in_ready", in_ready, 0);
        @(posedge Clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Steady state at count=1 with push and pop every cycle; mask 0 ops
    out_ready = 1'b0;
    set_src(7, 8'h40, 1'b0, 1'b0);
    issue(5'd7, 3'd6, 4'h0, 8'h40, 4'b0101);
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      set_src(7, 8'h40 + 8'(k), 1'b1, 1'b1);
      issue(5'd7, 3'(k), 4'h0, 8'h40 + 8'(k), 4'b0101);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_out_valid", out_valid, 1);
    end
    drain();

    // Reset mid-stream with a coincident operation
    out_ready = 1'b0;
    set_src(8, 8'h55, 1'b0, 1'b0);
    set_src(9, 8'h66, 1'b1, 1'b0);
    issue(5'd8, 3'd1, 4'hF, 8'h55, 4'b0000);
    issue(5'd9, 3'd2, 4'hF, 8'h66, 4'b0001);
    set_src(10, 8'hAA, 1'b1, 1'b1);
    select = 5'd10; flag_mask = 4'hF; in_valid = 1'b1; Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; in_valid = 1'b0;
    q.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_status", status, 0);
    chk("midrst_Dout", Dout, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("midrst_no_ghost", out_valid, 0);

    // Wide-datapath instance
    src_data2[2*16 +: 16] = 16'h8000;
    select2 = 2'd2; dest2 = 3'd5; flag_mask2 = 4'hF; in_valid2 = 1'b1;
    @(negedge Clk);
    chk("w16_in_ready", in_ready2, 1);
    @(posedge Clk); #1;
    in_valid2 = 1'b0;
    chk("w16_out_valid", out_valid2, 1);
    chk("w16_Dout", Dout2, 16'h8000);
    chk("w16_N", out_flags2[3], 1);
    chk("w16_Z", out_flags2[1], 0);
    chk("w16_status", status2, 4'b1000);
    chk("w16_out_dest", out_dest2, 3'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
